// File: rtl/decode_pkg.sv
// Shared constants and types for the BCH decode scheduler.
package decode_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SYND  = 3'd1;
  localparam logic [2:0] S_BM    = 3'd2;
  localparam logic [2:0] S_CHIEN = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_SYND  = S_SYND,
    ST_BM    = S_BM,
    ST_CHIEN = S_CHIEN,
    ST_NEXT  = S_NEXT,
    ST_DONE  = S_DONE
  } state_t;

  localparam logic [2:0] TP_NONE  = 3'd0;
  localparam logic [2:0] TP_MAX   = 3'd4;
  localparam logic [2:0] ERR_NONE = 3'd7;

  localparam logic MODE_HARD = 1'b0;
  localparam logic MODE_SOFT = 1'b1;

  localparam logic [1:0] CODE_T4 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [2:0] err;
    logic [2:0] tp;
  } best_t;

  localparam best_t BEST_CLEAR = '{valid: 1'b0, err: ERR_NONE, tp: TP_NONE};

  // Strict less-than keeps the earlier (lower-index) pattern on ties.
  function automatic logic is_better(input best_t b, input logic ok, input logic [2:0] err);
    return ok && (err < b.err);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage response watchdog: flags expiry on the (2^TO_W-1)th consecutive enabled cycle.
module stage_watchdog #(
  parameter int TO_W = 10
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'((1 << TO_W) - 2);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == LAST);

endmodule

// File: rtl/decode_scheduler.sv
// Sequencer for one BCH decode job: syndrome, early stop, BM/Chien passes and best-pattern selection.
module decode_scheduler
  import decode_pkg::*;
#(
  parameter int TO_W   = 10,
  parameter int NUM_TP = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_mode,
  input  logic [1:0] i_code,
  output logic       o_busy,
  output logic [1:0] o_code,
  output logic       o_mode,
  output logic       o_synd_start,
  input  logic       i_es_pulse,
  input  logic [2:0] i_es_tp,
  input  logic       i_synd_done,
  output logic       o_bm_start,
  output logic [2:0] o_tp_idx,
  input  logic       i_bm_done,
  output logic       o_chien_start,
  input  logic       i_chien_done,
  input  logic       i_chien_ok,
  input  logic [2:0] i_err_cnt,
  output logic       o_done,
  output logic [2:0] o_sel_tp,
  output logic [2:0] o_sel_err,
  output logic       o_fail,
  output logic       o_timeout
);

  state_t     r_state;
  best_t      r_best;
  logic       r_busy;
  logic [1:0] r_code;
  logic       r_mode;
  logic       r_synd_start;
  logic       r_bm_start;
  logic       r_chien_start;
  logic [2:0] r_tp_idx;
  logic       r_done;
  logic [2:0] r_sel_tp;
  logic [2:0] r_sel_err;
  logic       r_fail;
  logic       r_timeout;

  logic w_counting;
  logic w_resp;
  logic w_wd_clr;
  logic w_expire;

  assign w_counting = (r_state == ST_SYND) || (r_state == ST_BM) || (r_state == ST_CHIEN);
  assign w_resp     = ((r_state == ST_SYND)  && (i_es_pulse || i_synd_done)) ||
                      ((r_state == ST_BM)    && i_bm_done) ||
                      ((r_state == ST_CHIEN) && i_chien_done);
  // Any response ends the stage, so the count restarts for the next one.
  assign w_wd_clr   = i_rst || !w_counting || w_resp;

  stage_watchdog #(.TO_W(TO_W)) u_watchdog (
    .i_clk    (i_clk),
    .i_clr    (w_wd_clr),
    .i_en     (w_counting),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_best        <= BEST_CLEAR;
      r_busy        <= 1'b0;
      r_code        <= 2'b00;
      r_mode        <= MODE_HARD;
      r_synd_start  <= 1'b0;
      r_bm_start    <= 1'b0;
      r_chien_start <= 1'b0;
      r_tp_idx      <= TP_NONE;
      r_done        <= 1'b0;
      r_sel_tp      <= TP_NONE;
      r_sel_err     <= 3'd0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_synd_start  <= 1'b0;
      r_bm_start    <= 1'b0;
      r_chien_start <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_busy <= 1'b0;
          // r_busy is still high during the o_done cycle, which blocks a start there.
          if (i_start && !r_busy) begin
            r_busy       <= 1'b1;
            r_mode       <= i_mode;
            r_code       <= i_code;
            r_best       <= BEST_CLEAR;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
            r_synd_start <= 1'b1;
            r_state      <= ST_SYND;
          end
        end
        ST_SYND: begin
          if (i_es_pulse) begin
            r_sel_tp  <= i_es_tp;
            r_sel_err <= 3'd0;
            r_fail    <= 1'b0;
            r_state   <= ST_DONE;
          end else if (i_synd_done) begin
            r_tp_idx   <= 3'd1;
            r_bm_start <= 1'b1;
            r_state    <= ST_BM;
          end
        end
        ST_BM: begin
          if (i_bm_done) begin
            r_chien_start <= 1'b1;
            r_state       <= ST_CHIEN;
          end
        end
        ST_CHIEN: begin
          if (i_chien_done) begin
            if (is_better(r_best, i_chien_ok, i_err_cnt)) begin
              r_best <= '{valid: 1'b1, err: i_err_cnt, tp: r_tp_idx};
            end
            r_state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if ((r_mode == MODE_SOFT) && (r_tp_idx < TP_MAX)) begin
            r_tp_idx   <= r_tp_idx + 3'd1;
            r_bm_start <= 1'b1;
            r_state    <= ST_BM;
          end else begin
            r_sel_tp  <= r_best.tp;
            r_sel_err <= r_best.err;
            r_fail    <= !r_best.valid;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done   <= 1'b1;
          r_tp_idx <= TP_NONE;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Expiry only fires without a response; the later assignments override the stage's hold.
      if (w_expire && !w_resp) begin
        r_fail    <= 1'b1;
        r_timeout <= 1'b1;
        r_sel_tp  <= TP_NONE;
        r_sel_err <= ERR_NONE;
        r_state   <= ST_DONE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && (r_state == ST_NEXT)) begin
      assert (r_tp_idx <= 3'(NUM_TP));
    end
  end

  assign o_busy        = r_busy;
  assign o_code        = r_code;
  assign o_mode        = r_mode;
  assign o_synd_start  = r_synd_start;
  assign o_bm_start    = r_bm_start;
  assign o_chien_start = r_chien_start;
  assign o_tp_idx      = r_tp_idx;
  assign o_done        = r_done;
  assign o_sel_tp      = r_sel_tp;
  assign o_sel_err     = r_sel_err;
  assign o_fail        = r_fail;
  assign o_timeout     = r_timeout;

endmodule
